// File: rtl/pi_sequencer.sv
// Sequenced PI controller: one shared signed 32x32 multiplier computes the P, I
// and anti-windup products over a fixed IDLE->P->I->SUM->SAT->AW schedule.
module pi_sequencer #(
  parameter int          KP          = 1,
  parameter int          TsKI        = 0,
  parameter int          Kaw         = 0,
  parameter int unsigned SHIFT_KP    = 0,
  parameter int unsigned SHIFT_KI    = 0,
  parameter int          UPPER_LIMIT = 100,
  parameter int          LOWER_LIMIT = 0
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic               i_tick,
  input  logic               i_enable,
  input  logic               i_int_clr,
  input  logic               i_clr_ovr,
  input  logic signed [31:0] i_ref,
  input  logic signed [31:0] i_meas,
  output logic signed [31:0] o_u,
  output logic               o_valid,
  output logic               o_sat,
  output logic               o_busy,
  output logic               o_overrun,
  output logic [2:0]         o_dbg_state
);

  // Handshake: i_tick is a one-cycle request, accepted only in IDLE with
  // i_enable=1; o_valid is a one-cycle pulse with o_u/o_sat valid alongside it.

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_P    = 3'd1;
  localparam logic [2:0] S_I    = 3'd2;
  localparam logic [2:0] S_SUM  = 3'd3;
  localparam logic [2:0] S_SAT  = 3'd4;
  localparam logic [2:0] S_AW   = 3'd5;

  localparam logic signed [31:0] UL = UPPER_LIMIT;
  localparam logic signed [31:0] LL = LOWER_LIMIT;

  logic [2:0]         state_q, state_d;
  logic signed [31:0] err_q, err_d;
  logic signed [31:0] integ_q, integ_d;
  logic signed [31:0] p_term_q, p_term_d;
  logic signed [31:0] i_term_q, i_term_d;
  logic signed [31:0] u_raw_q, u_raw_d;
  logic signed [31:0] u_q, u_d;
  logic signed [31:0] aw_q, aw_d;
  logic               sat_q, sat_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic               clr_pend_q, clr_pend_d;

  logic               busy;
  logic signed [31:0] mul_a, mul_b;
  logic signed [63:0] mul_p;

  assign busy = (state_q != S_IDLE);

  // The single multiplier: operands are steered by the current state.
  always_comb begin
    mul_a = err_q;
    mul_b = KP;
    case (state_q)
      S_I:     begin mul_a = integ_q; mul_b = TsKI; end
      S_AW:    begin mul_a = aw_q;    mul_b = Kaw;  end
      default: begin mul_a = err_q;   mul_b = KP;   end
    endcase
    mul_p = 64'(mul_a) * 64'(mul_b);
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    integ_d    = integ_q;
    p_term_d   = p_term_q;
    i_term_d   = i_term_q;
    u_raw_d    = u_raw_q;
    u_d        = u_q;
    aw_d       = aw_q;
    sat_d      = sat_q;
    valid_d    = 1'b0;
    clr_pend_d = clr_pend_q;

    // Set wins over clear when a busy tick and i_clr_ovr coincide.
    if (busy && i_tick)  ovr_d = 1'b1;
    else if (i_clr_ovr)  ovr_d = 1'b0;
    else                 ovr_d = ovr_q;

    case (state_q)
      S_IDLE: begin
        if (i_int_clr) integ_d = '0;
        if (i_tick && i_enable) begin
          err_d   = i_ref - i_meas;
          state_d = S_P;
        end
      end
      S_P: begin
        p_term_d = 32'(mul_p >>> SHIFT_KP);
        state_d  = S_I;
      end
      S_I: begin
        i_term_d = 32'(mul_p >>> SHIFT_KI);
        state_d  = S_SUM;
      end
      S_SUM: begin
        u_raw_d = p_term_q + i_term_q;
        state_d = S_SAT;
      end
      S_SAT: begin
        if (u_raw_q > UL)      u_d = UL;
        else if (u_raw_q < LL) u_d = LL;
        else                   u_d = u_raw_q;
        sat_d   = (u_raw_q > UL) || (u_raw_q < LL);
        aw_d    = u_d - u_raw_q;
        valid_d = 1'b1;
        state_d = S_AW;
      end
      S_AW: begin
        // A clear requested during the sequence replaces this update.
        if (clr_pend_q || i_int_clr) integ_d = '0;
        else                         integ_d = integ_q + err_q + 32'(mul_p);
        clr_pend_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (busy && (state_q != S_AW) && i_int_clr) clr_pend_d = 1'b1;
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      state_q    <= S_IDLE;
      err_q      <= '0;
      integ_q    <= '0;
      p_term_q   <= '0;
      i_term_q   <= '0;
      u_raw_q    <= '0;
      u_q        <= '0;
      aw_q       <= '0;
      sat_q      <= 1'b0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      integ_q    <= integ_d;
      p_term_q   <= p_term_d;
      i_term_q   <= i_term_d;
      u_raw_q    <= u_raw_d;
      u_q        <= u_d;
      aw_q       <= aw_d;
      sat_q      <= sat_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  assign o_u         = u_q;
  assign o_valid     = valid_q;
  assign o_sat       = sat_q;
  assign o_busy      = busy;
  assign o_overrun   = ovr_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_pi_sequencer.sv
// Bench for pi_sequencer: four parameterisations share one stimulus stream and
// are compared every cycle against a sample-level reference model.
module tb_pi_sequencer;

  localparam int NI = 4;
  localparam int W  = 33;

  localparam int KP_C[NI]  = '{1, 0, 1, 3};
  localparam int TKI_C[NI] = '{0, 1, 0, 2};
  localparam int KAW_C[NI] = '{0, 0, 0, 1};
  localparam int SKP_C[NI] = '{0, 0, 1, 1};
  localparam int SKI_C[NI] = '{0, 0, 0, 2};
  localparam int UL_C[NI]  = '{100, 100, 100, 1000};
  localparam int LL_C[NI]  = '{0, 0, -100, -1000};

  logic clk = 1'b0;
  logic rst_n, tick, en, int_clr, clr_ovr;
  logic signed [31:0] r_in, m_in;

  logic signed [31:0] u_o[NI];
  logic               valid_o[NI], sat_o[NI], busy_o[NI], ovr_o[NI];
  logic [2:0]         dbg_o[NI];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pi_sequencer dut0 (
    .i_CLK(clk), .i_RST(rst_n), .i_tick(tick), .i_enable(en), .i_int_clr(int_clr),
    .i_clr_ovr(clr_ovr), .i_ref(r_in), .i_meas(m_in), .o_u(u_o[0]), .o_valid(valid_o[0]),
    .o_sat(sat_o[0]), .o_busy(busy_o[0]), .o_overrun(ovr_o[0]), .o_dbg_state(dbg_o[0]));

  pi_sequencer #(.KP(0), .TsKI(1), .Kaw(0)) dut1 (
    .i_CLK(clk), .i_RST(rst_n), .i_tick(tick), .i_enable(en), .i_int_clr(int_clr),
    .i_clr_ovr(clr_ovr), .i_ref(r_in), .i_meas(m_in), .o_u(u_o[1]), .o_valid(valid_o[1]),
    .o_sat(sat_o[1]), .o_busy(busy_o[1]), .o_overrun(ovr_o[1]), .o_dbg_state(dbg_o[1]));

  pi_sequencer #(.KP(1), .SHIFT_KP(1), .UPPER_LIMIT(100), .LOWER_LIMIT(-100)) dut2 (
    .i_CLK(clk), .i_RST(rst_n), .i_tick(tick), .i_enable(en), .i_int_clr(int_clr),
    .i_clr_ovr(clr_ovr), .i_ref(r_in), .i_meas(m_in), .o_u(u_o[2]), .o_valid(valid_o[2]),
    .o_sat(sat_o[2]), .o_busy(busy_o[2]), .o_overrun(ovr_o[2]), .o_dbg_state(dbg_o[2]));

  pi_sequencer #(.KP(3), .TsKI(2), .Kaw(1), .SHIFT_KP(1), .SHIFT_KI(2),
                 .UPPER_LIMIT(1000), .LOWER_LIMIT(-1000)) dut3 (
    .i_CLK(clk), .i_RST(rst_n), .i_tick(tick), .i_enable(en), .i_int_clr(int_clr),
    .i_clr_ovr(clr_ovr), .i_ref(r_in), .i_meas(m_in), .o_u(u_o[3]), .o_valid(valid_o[3]),
    .o_sat(sat_o[3]), .o_busy(busy_o[3]), .o_overrun(ovr_o[3]), .o_dbg_state(dbg_o[3]));

  // Reference model: one sample's full result is computed at acceptance and
  // released on the cycle the output is due.
  logic [W-1:0] exp_q[NI][$];
  int m_integ[NI], m_next[NI], m_u[NI];
  bit m_sat[NI];
  int phase = -1;
  bit m_valid, m_ovr, m_pend;

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_sample(input int k, input int e);
    int p, i, raw, u, aw;
    p   = int'((longint'(e) * KP_C[k]) >>> SKP_C[k]);
    i   = int'((longint'(m_integ[k]) * TKI_C[k]) >>> SKI_C[k]);
    raw = p + i;
    u   = (raw > UL_C[k]) ? UL_C[k] : (raw < LL_C[k]) ? LL_C[k] : raw;
    aw  = u - raw;
    m_next[k] = m_integ[k] + e + int'(longint'(aw) * KAW_C[k]);
    exp_q[k].push_back({(u != raw), u});
  endtask

  task automatic model_edge();
    m_valid = 1'b0;
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        m_integ[k] = 0; m_u[k] = 0; m_sat[k] = 1'b0; exp_q[k].delete();
      end
      phase = -1; m_ovr = 1'b0; m_pend = 1'b0;
    end else begin
      if (phase >= 0 && tick) m_ovr = 1'b1;
      else if (clr_ovr)       m_ovr = 1'b0;
      if (phase < 0) begin
        if (int_clr) for (int k = 0; k < NI; k++) m_integ[k] = 0;
        if (tick && en) begin
          for (int k = 0; k < NI; k++) model_sample(k, int'(r_in - m_in));
          phase = 0;
        end
      end else begin
        phase++;
        if (phase == 4) begin
          m_valid = 1'b1;
          for (int k = 0; k < NI; k++) {m_sat[k], m_u[k]} = exp_q[k].pop_front();
        end
        if (phase == 5) begin
          for (int k = 0; k < NI; k++) m_integ[k] = (m_pend || int_clr) ? 0 : m_next[k];
          m_pend = 1'b0;
          phase  = -1;
        end else if (int_clr) begin
          m_pend = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      check_val($sformatf("u[%0d]", k), u_o[k], m_u[k]);
      check_val($sformatf("sat[%0d]", k), sat_o[k], m_sat[k]);
      check_val($sformatf("valid[%0d]", k), valid_o[k], m_valid);
      check_val($sformatf("busy[%0d]", k), busy_o[k], (phase >= 0));
      check_val($sformatf("overrun[%0d]", k), ovr_o[k], m_ovr);
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // Pulses one tick, then waits (bounded) for o_valid; returns edges after acceptance.
  task automatic drive_sample(input int rv, input int mv, output int lat);
    r_in = rv; m_in = mv; tick = 1'b1; en = 1'b1;
    run_cycle();
    tick = 1'b0;
    lat = 0;
    do begin
      run_cycle();
      lat++;
    end while (!valid_o[0] && lat < 12);
  endtask

  int lat, nv;

  initial begin
    rst_n = 1'b0; tick = 1'b0; en = 1'b0; int_clr = 1'b0; clr_ovr = 1'b0;
    r_in = '0; m_in = '0;
    run_n(2);
    check_val("reset_u", u_o[0], 0);
    check_val("reset_busy", busy_o[0], 0);
    rst_n = 1'b1;
    run_n(1);

    // Basic proportional path and latency
    drive_sample(50, 20, lat);
    check_val("lat_p", lat, 4);
    check_val("u_50_20", u_o[0], 30);
    check_val("sat_50_20", sat_o[0], 0);
    run_n(2);

    drive_sample(500, 0, lat);
    check_val("u_hi_clamp", u_o[0], 100);
    check_val("sat_hi_clamp", sat_o[0], 1);
    run_n(2);
    drive_sample(0, 9, lat);
    check_val("u_lo_clamp", u_o[0], 0);
    check_val("sat_lo_clamp", sat_o[0], 1);
    run_n(2);

    // Integral-only instance accumulates err each sample
    int_clr = 1'b1; run_cycle(); int_clr = 1'b0;
    drive_sample(10, 0, lat); check_val("i_acc0", u_o[1], 0);  run_n(3);
    drive_sample(10, 0, lat); check_val("i_acc1", u_o[1], 10); run_n(3);
    drive_sample(10, 0, lat); check_val("i_acc2", u_o[1], 20); run_n(3);

    drive_sample(0, 7, lat);
    check_val("u_ashift", u_o[2], -4);
    check_val("sat_ashift", sat_o[2], 0);
    run_n(2);

    // Tick with enable low is ignored without overrun
    tick = 1'b1; en = 1'b0; run_cycle(); tick = 1'b0;
    check_val("dis_busy", busy_o[0], 0);
    check_val("dis_ovr", ovr_o[0], 0);

    // Overrun: second tick three cycles after the first
    r_in = 50; m_in = 20; en = 1'b1; tick = 1'b1; run_cycle(); tick = 1'b0;
    run_n(2);
    tick = 1'b1; run_cycle(); tick = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      run_cycle();
      if (valid_o[0]) nv++;
    end
    check_val("ovr_one_valid", nv, 1);
    check_val("ovr_set", ovr_o[0], 1);
    clr_ovr = 1'b1; run_cycle(); clr_ovr = 1'b0;
    check_val("ovr_clr", ovr_o[0], 0);

    // Set wins over clear
    tick = 1'b1; run_cycle();
    clr_ovr = 1'b1; run_cycle(); tick = 1'b0; clr_ovr = 1'b0;
    check_val("ovr_set_wins", ovr_o[0], 1);
    run_n(6);
    clr_ovr = 1'b1; run_cycle(); clr_ovr = 1'b0;

    // Reset while in SUM aborts the sequence
    tick = 1'b1; r_in = 50; m_in = 20; run_cycle(); tick = 1'b0;
    run_n(2);
    rst_n = 1'b0; run_cycle();
    check_val("rst_mid_u", u_o[1], 0);
    check_val("rst_mid_valid", valid_o[0], 0);
    check_val("rst_mid_busy", busy_o[0], 0);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      if (valid_o[0]) nv++;
    end
    check_val("rst_no_valid", nv, 0);
    drive_sample(50, 20, lat);
    check_val("post_rst_lat", lat, 4);
    check_val("post_rst_u", u_o[0], 30);
    check_val("post_rst_integ0", u_o[1], 0);
    run_n(2);

    // Randomized traffic
    for (int c = 0; c < 700; c++) begin
      tick    = ($urandom_range(3) == 0);
      en      = ($urandom_range(3) != 0);
      int_clr = ($urandom_range(15) == 0);
      clr_ovr = ($urandom_range(7) == 0);
      rst_n   = ($urandom_range(149) != 0);
      if ($urandom_range(3) == 0) begin
        r_in = $urandom; m_in = $urandom;
      end else begin
        r_in = int'($urandom_range(400)) - 200;
        m_in = int'($urandom_range(400)) - 200;
      end
      run_cycle();
    end
    tick = 1'b0; int_clr = 1'b0; clr_ovr = 1'b0; rst_n = 1'b1;
    run_n(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
